// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state, opcode, funct and mux-select constants for the multicycle MIPS controller
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECUTE  = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_ADDIEXEC = 4'd9,
        ST_ADDIWB   = 4'd10,
        ST_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALURES = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - R-type funct to ALU operation map with illegal-funct flag
// Ports: is_rtype (instruction is R-type), funct (instr[5:0]),
//        alu_control (ALU op), funct_illegal (R-type funct not supported)
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic       is_rtype,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        if (is_rtype) begin
            case (funct)
                FN_ADD:  alu_control = ALU_ADD;
                FN_SUB:  alu_control = ALU_SUB;
                FN_AND:  alu_control = ALU_AND;
                FN_OR:   alu_control = ALU_OR;
                FN_SLT:  alu_control = ALU_SLT;
                default: funct_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - control FSM sequencing the multicycle MIPS datapath
// Ports: clk, rst_n (async active-low); Opcode/Funct from IR, Zero flag,
//        Mem_Ready handshake; datapath mux selects, enables, ALU_Control,
//        Instr_Done and Illegal_Op pulses.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       Mem_Ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALU_Control,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       Instr_Done,
    output logic       Illegal_Op
);

    state_t     state;
    state_t     state_next;
    logic [2:0] dec_alu;
    logic       dec_illegal;

    alu_decoder u_alu_decoder (
        .is_rtype      (Opcode == OP_RTYPE),
        .funct         (Funct),
        .alu_control   (dec_alu),
        .funct_illegal (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= state_t'(RESET_STATE);
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALU_Control = 3'b000;
        PCSrc       = PC_ALURES;
        PCEn        = 1'b0;
        Instr_Done  = 1'b0;
        Illegal_Op  = 1'b0;

        case (state)
            ST_FETCH: begin
                MemRead     = 1'b1;
                ALUSrcB     = SRCB_FOUR;
                ALU_Control = ALU_ADD;
                // IR load and PC+4 only commit on the cycle memory delivers the word
                IRWrite     = Mem_Ready;
                PCEn        = Mem_Ready;
                if (Mem_Ready) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                // Precompute the branch target into ALUOut regardless of opcode
                ALUSrcB     = SRCB_IMMSH;
                ALU_Control = ALU_ADD;
                case (Opcode)
                    OP_LW, OP_SW: state_next = ST_MEMADR;
                    OP_BEQ:       state_next = ST_BRANCH;
                    OP_ADDI:      state_next = ST_ADDIEXEC;
                    OP_J:         state_next = ST_JUMP;
                    OP_RTYPE: begin
                        if (dec_illegal) begin
                            Illegal_Op = 1'b1;
                            Instr_Done = 1'b1;
                            state_next = ST_FETCH;
                        end else begin
                            state_next = ST_EXECUTE;
                        end
                    end
                    default: begin
                        Illegal_Op = 1'b1;
                        Instr_Done = 1'b1;
                        state_next = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_IMM;
                ALU_Control = ALU_ADD;
                state_next  = (Opcode == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
            end
            ST_MEMREAD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (Mem_Ready) state_next = ST_MEMWB;
            end
            ST_MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                Instr_Done = 1'b1;
                state_next = ST_FETCH;
            end
            ST_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (Mem_Ready) begin
                    Instr_Done = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_EXECUTE: begin
                ALUSrcA     = 1'b1;
                ALU_Control = dec_alu;
                state_next  = ST_ALUWB;
            end
            ST_ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                Instr_Done = 1'b1;
                state_next = ST_FETCH;
            end
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALU_Control = ALU_SUB;
                PCSrc       = PC_ALUOUT;
                PCEn        = Zero;
                Instr_Done  = 1'b1;
                state_next  = ST_FETCH;
            end
            ST_ADDIEXEC: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_IMM;
                ALU_Control = ALU_ADD;
                state_next  = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                RegWrite   = 1'b1;
                Instr_Done = 1'b1;
                state_next = ST_FETCH;
            end
            ST_JUMP: begin
                PCSrc      = PC_JUMP;
                PCEn       = 1'b1;
                Instr_Done = 1'b1;
                state_next = ST_FETCH;
            end
            default: state_next = ST_FETCH;
        endcase

        // Outputs are quiet for the whole reset window, not just after the edge
        if (!rst_n) begin
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegDst      = 1'b0;
            MemtoReg    = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = SRCB_REG;
            ALU_Control = 3'b000;
            PCSrc       = PC_ALURES;
            PCEn        = 1'b0;
            Instr_Done  = 1'b0;
            Illegal_Op  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       Mem_Ready;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALU_Control;
    logic [1:0] PCSrc;
    logic       PCEn, Instr_Done, Illegal_Op;

    multicycle_controller #(.RESET_STATE(4'd0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Opcode      (Opcode),
        .Funct       (Funct),
        .Zero        (Zero),
        .Mem_Ready   (Mem_Ready),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALU_Control (ALU_Control),
        .PCSrc       (PCSrc),
        .PCEn        (PCEn),
        .Instr_Done  (Instr_Done),
        .Illegal_Op  (Illegal_Op)
    );

    always #5 clk = ~clk;

    // Bit order: IorD MemRead MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA
    //            ALUSrcB[1:0] ALU_Control[2:0] PCSrc[1:0] PCEn Instr_Done Illegal_Op
    logic [17:0] obs;
    assign obs = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, ALU_Control, PCSrc, PCEn, Instr_Done, Illegal_Op};

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [17:0] seq_exp [16];
    logic        seq_rdy [16];
    int          seq_len;

    // Expected output vectors, one per state, written from the state/output table
    function automatic logic [17:0] e_fetch(input logic r);
        return {1'b0, 1'b1, 1'b0, r, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b010, 2'b00, r, 1'b0, 1'b0};
    endfunction
    function automatic logic [17:0] e_decode(input logic ill);
        return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b010, 2'b00, 1'b0, ill, ill};
    endfunction
    localparam logic [17:0] E_MEMADR   = {8'b0000_0001, 2'b10, 3'b010, 2'b00, 3'b000};
    localparam logic [17:0] E_MEMREAD  = {8'b1100_0000, 2'b00, 3'b000, 2'b00, 3'b000};
    localparam logic [17:0] E_MEMWB    = {8'b0000_0110, 2'b00, 3'b000, 2'b00, 3'b010};
    localparam logic [17:0] E_ALUWB    = {8'b0000_1010, 2'b00, 3'b000, 2'b00, 3'b010};
    localparam logic [17:0] E_ADDIEXEC = {8'b0000_0001, 2'b10, 3'b010, 2'b00, 3'b000};
    localparam logic [17:0] E_ADDIWB   = {8'b0000_0010, 2'b00, 3'b000, 2'b00, 3'b010};
    localparam logic [17:0] E_JUMP     = {8'b0000_0000, 2'b00, 3'b000, 2'b10, 3'b110};
    function automatic logic [17:0] e_memwrite(input logic r);
        return {8'b1010_0000, 2'b00, 3'b000, 2'b00, 1'b0, r, 1'b0};
    endfunction
    function automatic logic [17:0] e_execute(input logic [2:0] alu);
        return {8'b0000_0001, 2'b00, alu, 2'b00, 3'b000};
    endfunction
    function automatic logic [17:0] e_branch(input logic z);
        return {8'b0000_0001, 2'b00, 3'b110, 2'b01, z, 1'b1, 1'b0};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; Opcode = 6'd0; Funct = 6'd0; Zero = 1'b0; Mem_Ready = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (obs !== 18'd0) $display("FAIL reset_outputs: got %b expected %b", obs, 18'd0);
        else pass_cnt++;
        Mem_Ready = 1'b0;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (obs !== e_fetch(1'b0)) $display("FAIL reset_release_fetch: got %b expected %b", obs, e_fetch(1'b0));
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (obs !== e_fetch(1'b0)) $display("FAIL fetch_hold: got %b expected %b", obs, e_fetch(1'b0));
        else pass_cnt++;
    endtask

    task automatic test_seq(input string name);
        for (int i = 0; i < seq_len; i++) begin
            Mem_Ready = seq_rdy[i];
            #1;
            total_cnt++;
            if (obs !== seq_exp[i]) $display("FAIL %s cycle %0d: got %b expected %b", name, i, obs, seq_exp[i]);
            else pass_cnt++;
            @(negedge clk);
        end
        Mem_Ready = 1'b0;
        #1;
        total_cnt++;
        if (obs !== e_fetch(1'b0)) $display("FAIL %s end_fetch: got %b expected %b", name, obs, e_fetch(1'b0));
        else pass_cnt++;
    endtask

    task automatic test_lw();
        Opcode = 6'b100011;
        seq_len = 5;
        seq_exp[0] = e_fetch(1'b1); seq_exp[1] = e_decode(1'b0); seq_exp[2] = E_MEMADR;
        seq_exp[3] = E_MEMREAD;     seq_exp[4] = E_MEMWB;
        for (int i = 0; i < 5; i++) seq_rdy[i] = 1'b1;
        test_seq("lw");
    endtask

    task automatic test_rtype(input logic [5:0] fn, input logic [2:0] alu);
        Opcode = 6'b000000; Funct = fn;
        seq_len = 4;
        seq_exp[0] = e_fetch(1'b1); seq_exp[1] = e_decode(1'b0);
        seq_exp[2] = e_execute(alu); seq_exp[3] = E_ALUWB;
        for (int i = 0; i < 4; i++) seq_rdy[i] = 1'b1;
        test_seq("rtype");
    endtask

    task automatic test_beq(input logic z);
        Opcode = 6'b000100; Zero = z;
        seq_len = 3;
        seq_exp[0] = e_fetch(1'b1); seq_exp[1] = e_decode(1'b0); seq_exp[2] = e_branch(z);
        for (int i = 0; i < 3; i++) seq_rdy[i] = 1'b1;
        test_seq("beq");
        Zero = 1'b0;
    endtask

    task automatic test_addi_j();
        Opcode = 6'b001000;
        seq_len = 4;
        seq_exp[0] = e_fetch(1'b1); seq_exp[1] = e_decode(1'b0);
        seq_exp[2] = E_ADDIEXEC;    seq_exp[3] = E_ADDIWB;
        for (int i = 0; i < 4; i++) seq_rdy[i] = 1'b1;
        test_seq("addi");
        Opcode = 6'b000010;
        seq_len = 3;
        seq_exp[0] = e_fetch(1'b1); seq_exp[1] = e_decode(1'b0); seq_exp[2] = E_JUMP;
        test_seq("j");
    endtask

    task automatic test_sw_stall();
        Opcode = 6'b101011;
        seq_len = 10;
        for (int i = 0; i < 3; i++) begin seq_exp[i] = e_fetch(1'b0); seq_rdy[i] = 1'b0; end
        seq_exp[3] = e_fetch(1'b1);  seq_rdy[3] = 1'b1;
        seq_exp[4] = e_decode(1'b0); seq_rdy[4] = 1'b1;
        seq_exp[5] = E_MEMADR;       seq_rdy[5] = 1'b1;
        for (int i = 6; i < 9; i++) begin seq_exp[i] = e_memwrite(1'b0); seq_rdy[i] = 1'b0; end
        seq_exp[9] = e_memwrite(1'b1); seq_rdy[9] = 1'b1;
        test_seq("sw_stall");
    endtask

    task automatic test_illegal();
        Opcode = 6'b111111; Funct = 6'b100000;
        seq_len = 2;
        seq_exp[0] = e_fetch(1'b1); seq_exp[1] = e_decode(1'b1);
        seq_rdy[0] = 1'b1; seq_rdy[1] = 1'b1;
        test_seq("illegal_opcode");
        Opcode = 6'b000000; Funct = 6'b000111;
        test_seq("illegal_funct");
    endtask

    task automatic test_reset_mid();
        Opcode = 6'b101011;
        seq_len = 3;
        seq_exp[0] = e_fetch(1'b1); seq_exp[1] = e_decode(1'b0); seq_exp[2] = E_MEMADR;
        for (int i = 0; i < 3; i++) seq_rdy[i] = 1'b1;
        for (int i = 0; i < seq_len; i++) begin
            Mem_Ready = seq_rdy[i];
            @(negedge clk);
        end
        Mem_Ready = 1'b0;
        #1;
        total_cnt++;
        if (obs !== e_memwrite(1'b0)) $display("FAIL mid_memwrite: got %b expected %b", obs, e_memwrite(1'b0));
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (MemWrite !== 1'b0 || obs !== 18'd0) $display("FAIL mid_reset_drop: got %b expected %b", obs, 18'd0);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total_cnt++;
            if (obs !== 18'd0) $display("FAIL mid_reset_hold %0d: got %b expected %b", i, obs, 18'd0);
            else pass_cnt++;
        end
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (obs !== e_fetch(1'b0)) $display("FAIL mid_reset_release: got %b expected %b", obs, e_fetch(1'b0));
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype(6'b100010, 3'b110);
        test_rtype(6'b101010, 3'b111);
        test_rtype(6'b100000, 3'b010);
        test_rtype(6'b100100, 3'b000);
        test_rtype(6'b100101, 3'b001);
        test_beq(1'b1);
        test_beq(1'b0);
        test_addi_j();
        test_sw_stall();
        test_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
